// File: rtl/button_debounce_pkg.sv
// Shared constants for the push-button debouncer: FSM encodings and debounce lengths.
package button_debounce_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE         = ST_IDLE,
    PRESS_WAIT   = ST_PRESS_WAIT,
    HELD         = ST_HELD,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; clears to 0 on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronized input, stable-count FSM, registered level and edge pulses.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int CNT_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 btn_sync;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_in),
    .q       (btn_sync)
  );

  // Counter stops at LAST and is cleared on WAIT entry, so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_sync) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            state       <= HELD;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!btn_sync) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_sync) begin
            state <= HELD;
          end else if (cnt == LAST) begin
            state         <= IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
